// File: rtl/conv2_accum_stage.sv
// Conv layer 2 accumulate stage: adder tree, window accumulator, bias, round/shift/saturate.
// Optional CONV2_ACC_RELU_EN clamps negative activations to zero after saturation.
module conv2_accum_stage #(
  parameter int NUM_BEATS = 4,
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 4,
  parameter int OUT_W     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [11:0]      prod1,
  input  logic signed [11:0]      prod2,
  input  logic signed [11:0]      prod3,
  input  logic signed [11:0]      prod4,
  input  logic signed [11:0]      prod5,
  input  logic signed [11:0]      prod6,
  input  logic signed [11:0]      bias,
  input  logic                    clear,
  output logic signed [OUT_W-1:0] result,
  output logic                    out_valid,
  output logic [7:0]              beat_cnt
);

  localparam logic [7:0]              LAST_CNT = 8'(NUM_BEATS - 1);
  localparam logic signed [ACC_W:0]   RND_C    = (ACC_W+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0]   SAT_MAX  = (ACC_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [ACC_W:0]   SAT_MIN  = ~SAT_MAX;

  function automatic logic signed [OUT_W-1:0] sat_fn(input logic signed [ACC_W:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[OUT_W-1:0];
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

  logic [7:0]              beat_cnt_r;
  logic                    va_r, last_a_r;
  logic signed [11:0]      bias_a_r;
  logic signed [12:0]      s01_r, s23_r, s45_r;
  logic                    vb_r, last_b_r;
  logic signed [11:0]      bias_b_r;
  logic signed [14:0]      sb_r;
  logic signed [ACC_W-1:0] acc_r, fin_r;
  logic                    vfin_r;
  logic signed [OUT_W-1:0] result_r;
  logic                    out_valid_r;

  logic signed [12:0]      s01_s, s23_s, s45_s;
  logic signed [14:0]      sb_s;
  logic signed [ACC_W-1:0] sb_ext_s, bias_ext_s, acc_sum_s, fin_sum_s;
  logic                    last_s;
  logic signed [ACC_W:0]   rnd_s, shr_s;
  logic signed [OUT_W-1:0] sat_s, act_s;

  assign s01_s      = {prod1[11], prod1} + {prod2[11], prod2};
  assign s23_s      = {prod3[11], prod3} + {prod4[11], prod4};
  assign s45_s      = {prod5[11], prod5} + {prod6[11], prod6};
  assign last_s     = (beat_cnt_r == LAST_CNT);
  assign sb_s       = {{2{s01_r[12]}}, s01_r} + {{2{s23_r[12]}}, s23_r} + {{2{s45_r[12]}}, s45_r};
  assign sb_ext_s   = {{(ACC_W-15){sb_r[14]}}, sb_r};
  assign bias_ext_s = {{(ACC_W-12){bias_b_r[11]}}, bias_b_r};
  assign acc_sum_s  = acc_r + sb_ext_s;
  assign fin_sum_s  = acc_sum_s + bias_ext_s;

  // Stage A: pair sums, beat counter and last-beat tagging; idle cycles hold data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_r <= 8'd0;
      va_r       <= 1'b0;
      last_a_r   <= 1'b0;
      bias_a_r   <= 12'sd0;
      s01_r      <= 13'sd0;
      s23_r      <= 13'sd0;
      s45_r      <= 13'sd0;
    end else if (clear) begin
      beat_cnt_r <= 8'd0;
      va_r       <= 1'b0;
    end else if (in_valid) begin
      beat_cnt_r <= last_s ? 8'd0 : beat_cnt_r + 8'd1;
      va_r       <= 1'b1;
      last_a_r   <= last_s;
      bias_a_r   <= bias;
      s01_r      <= s01_s;
      s23_r      <= s23_s;
      s45_r      <= s45_s;
    end else begin
      va_r       <= 1'b0;
    end
  end

  // Stage B: beat sum, with last flag and bias riding along
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_r     <= 1'b0;
      last_b_r <= 1'b0;
      bias_b_r <= 12'sd0;
      sb_r     <= 15'sd0;
    end else if (clear) begin
      vb_r     <= 1'b0;
    end else begin
      vb_r <= va_r;
      if (va_r) begin
        sb_r     <= sb_s;
        last_b_r <= last_a_r;
        bias_b_r <= bias_a_r;
      end
    end
  end

  // Stage C: accumulator restarts on the same edge that finalises a window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r  <= '0;
      fin_r  <= '0;
      vfin_r <= 1'b0;
    end else if (clear) begin
      acc_r  <= '0;
      vfin_r <= 1'b0;
    end else if (vb_r && last_b_r) begin
      fin_r  <= fin_sum_s;
      acc_r  <= '0;
      vfin_r <= 1'b1;
    end else if (vb_r) begin
      acc_r  <= acc_sum_s;
      vfin_r <= 1'b0;
    end else begin
      vfin_r <= 1'b0;
    end
  end

  // Round half up, arithmetic shift, saturate, optional rectify
  always_comb begin
    rnd_s = {fin_r[ACC_W-1], fin_r} + RND_C;
    shr_s = rnd_s >>> SHIFT;
    sat_s = sat_fn(shr_s);
`ifdef CONV2_ACC_RELU_EN
    if (sat_s[OUT_W-1]) begin
      act_s = {OUT_W{1'b0}};
    end else begin
      act_s = sat_s;
    end
`else
    act_s = sat_s;
`endif
  end

  // Stage D: output register; unaffected by clear so an in-flight pixel still emits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r    <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (vfin_r) begin
      result_r    <= act_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign result    = result_r;
  assign out_valid = out_valid_r;
  assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_conv2_accum_stage.sv
// Scoreboard bench for conv2_accum_stage: window-sum reference model, decoupled output monitor.
module tb_conv2_accum_stage;
  localparam int NB = 4;
  localparam int SH = 4;
  localparam int OW = 6;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic clear = 1'b0;
  logic signed [11:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0, p5 = '0, p6 = '0;
  logic signed [11:0] bias = '0;
  logic signed [OW-1:0] result;
  logic out_valid;
  logic [7:0] beat_cnt;

  conv2_accum_stage #(.NUM_BEATS(NB), .ACC_W(AW), .SHIFT(SH), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .prod1(p1), .prod2(p2), .prod3(p3), .prod4(p4), .prod5(p5), .prod6(p6),
    .bias(bias), .clear(clear), .result(result), .out_valid(out_valid), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int edge_no; } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  longint m_sum = 0;
  int m_cnt = 0;

  // reference: total of the window plus bias, rounded half up, floor-shifted, clamped
  function automatic int ref_act(longint tot);
    longint r;
    int lo;
    r = (tot + ((longint'(1) << SH) / 2)) >>> SH;
`ifdef CONV2_ACC_RELU_EN
    lo = 0;
`else
    lo = -(1 << (OW - 1));
`endif
    if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
    if (r < lo) r = lo;
    return int'(r);
  endfunction

  task automatic set_all(input int x);
    p1 = 12'(x); p2 = 12'(x); p3 = 12'(x); p4 = 12'(x); p5 = 12'(x); p6 = 12'(x);
  endtask

  task automatic set_rand();
    p1 = 12'($urandom_range(0, 4095)); p2 = 12'($urandom_range(0, 4095));
    p3 = 12'($urandom_range(0, 4095)); p4 = 12'($urandom_range(0, 4095));
    p5 = 12'($urandom_range(0, 4095)); p6 = 12'($urandom_range(0, 4095));
  endtask

  task automatic step(input logic v, input logic clr);
    exp_t e;
    in_valid = v;
    clear = clr;
    @(posedge clk);
    edge_cnt++;
    if (reset || clr) begin
      m_cnt = 0;
      m_sum = 0;
    end else if (v) begin
      m_sum += longint'(p1) + longint'(p2) + longint'(p3) + longint'(p4) + longint'(p5) + longint'(p6);
      m_cnt++;
      if (m_cnt == NB) begin
        e.val = ref_act(m_sum + longint'(bias));
        e.edge_no = edge_cnt + 3;
        q.push_back(e);
        m_cnt = 0;
        m_sum = 0;
      end
    end
    #1;
    total++;
    if (int'(beat_cnt) != m_cnt) begin
      bad++;
      $display("FAIL beat_cnt at edge %0d: got %0d want %0d", edge_cnt, beat_cnt, m_cnt);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // monitor: every pulse must match the oldest expectation in value and arrival edge
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected out_valid at edge %0d result=%0d", edge_cnt, result);
      end else begin
        e = q.pop_front();
        if (int'(result) != e.val || e.edge_no != edge_cnt) begin
          bad++;
          $display("FAIL result: got %0d at edge %0d want %0d at edge %0d", result, edge_cnt, e.val, e.edge_no);
        end
      end
    end else if (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
      total++;
      bad++;
      $display("FAIL missing out_valid: want %0d at edge %0d", q[0].val, q[0].edge_no);
      void'(q.pop_front());
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b0);
    chk("reset result", int'(result), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset beat_cnt", int'(beat_cnt), 0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    idle(2);

    // all prods 10, bias 0 -> 15
    set_all(10); bias = 12'sd0;
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    idle(5);
    // saturate high
    set_all(2047);
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    idle(5);
    // saturate low / rectified
    set_all(-100);
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    idle(5);
    // bias only
    set_all(0); bias = 12'sd100;
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    bias = 12'sd0;
    idle(5);
    // interleaved garbage then back-to-back window
    for (int i = 0; i < NB; i++) begin
      set_all(10); step(1'b1, 1'b0);
      set_all(500); step(1'b0, 1'b0);
    end
    set_all(1);
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    idle(5);
    // partial window flushed by clear (beat in the clear cycle dropped)
    set_all(10);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    set_all(1);
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    idle(5);
    // asynchronous reset mid-window
    set_all(7);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    q.delete(); m_cnt = 0; m_sum = 0;
    chk("async reset result", int'(result), 0);
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset beat_cnt", int'(beat_cnt), 0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    set_all(10);
    for (int i = 0; i < NB; i++) step(1'b1, 1'b0);
    idle(5);

    // randomized traffic, clears only when no pixel is in flight
    for (int i = 0; i < 400; i++) begin
      set_rand();
      bias = 12'($urandom_range(0, 4095));
      if (q.size() == 0 && $urandom_range(0, 19) == 0) step(1'($urandom_range(0, 1)), 1'b1);
      else step(1'($urandom_range(0, 9) < 7), 1'b0);
    end
    idle(6);
    chk("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv2_accum_stage.md
Name: conv2_accum_stage

Overview:
- Consumer side of the Conv Layer 2 multiply stage. Each valid beat delivers six signed 12-bit products plus a done/valid strobe.
- Reduces each beat through a pipelined adder tree and accumulates NUM_BEATS beats into one output pixel.
- Adds a bias, then rounds, shifts and saturates the result to a 6-bit activation for the next layer.
- Emits a one-cycle out_valid pulse per completed pixel.

Parameters:
- NUM_BEATS, 4: valid product beats accumulated per output pixel (range 1..255).
- ACC_W, 20: accumulator width. Must satisfy ACC_W >= 16 + clog2(NUM_BEATS).
- SHIFT, 4: right-shift applied before saturation (range 0..ACC_W-2).
- OUT_W, 6: output activation width, signed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  beat strobe; driven by the multiply stage's done
- prod1..prod6  in  12 each  signed products; sampled only when in_valid=1
- bias  in  12  signed bias; sampled on the last beat of a window
- clear  in  1  synchronous flush of the partial window and the pipeline
- result  out  OUT_W  signed activation
- out_valid  out  1  one-cycle pulse marking result valid
- beat_cnt  out  8  valid beats accumulated in the current window

Behaviour:
- Reset (async, active-high): all pipeline registers, valid bits, accumulator, beat_cnt, result and out_valid go to 0 immediately. The first beat after release starts a new window.
- Stage A, registered on the edge where in_valid=1:
  - s01=prod1+prod2, s23=prod3+prod4, s45=prod5+prod6, each sign-extended to 13 bits.
  - vA=in_valid. Each beat tags a last flag, set when beat_cnt==NUM_BEATS-1 at sampling. Bias is captured with the last beat.
  - When in_valid=0, stage A data holds and vA=0. Product values on invalid cycles, including the zeros the multiply stage drives, never reach the accumulator.
- Stage B: sB=s01+s23+s45, 15-bit signed; vB=vA; the last flag and bias travel with the beat.
- Stage C, accumulator, on vB=1:
  - Non-last beat: acc <= acc + sext(sB).
  - Last beat: fin <= acc + sext(sB) + sext(bias); acc <= 0 in the same edge.
  - Back-to-back windows therefore need no bubble.
- Stage D, on a valid fin:
  - r = (fin + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift, round half up.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-32, 31] by default.
  - Register into result and pulse out_valid for exactly 1 cycle. result holds until the next pulse.
- Latency: counting the edge that samples the last beat as edge 1, out_valid is high after edge 4. Sustained throughput is one beat per clock.
- beat_cnt:
  - Increments on each sampled beat.
  - On the last beat it returns to 0.
  - NUM_BEATS=1 makes every beat a last beat.
- clear:
  - Zeroes acc, beat_cnt, vA, vB and the pending fin valid on the next edge.
  - A beat presented in the same cycle as clear is dropped.
  - A result already in stage D still emits.
- Arithmetic: all two's complement signed. The accumulator wraps if ACC_W is violated; an overflow flag is not provided.

Optional Feature:
- Macro CONV2_ACC_RELU_EN.
- Defined: after saturation, negative values are forced to 0, so result lies in [0, 31].
- Undefined: signed saturation only; result lies in [-32, 31].

Test Plan:
- NUM_BEATS=4, SHIFT=4, bias=0. Four consecutive beats with all prods=10 (beat sum 60, total 240, rounded 248>>4) -> result=15, out_valid pulse 4 edges after the last beat, beat_cnt back to 0.
- All prods=2047 for 4 beats, bias=0 -> fin=49128 -> result=31 (saturated high).
- All prods=-100 for 4 beats -> fin=-2400 -> result=-32 without the macro, 0 with CONV2_ACC_RELU_EN.
- All prods=0, bias=100 -> (100+8)>>4 -> result=6.
- Window 1 prods=10 (interleaved with in_valid=0 cycles carrying prods=500), then immediately window 2 prods=1 on back-to-back beats -> results 15 then 2 (24+8>>4), garbage ignored, no lost beat.
- Two beats of prods=10, then clear, then four beats of prods=1 -> single result=2. Separately, assert reset mid-window -> outputs 0 at once, and the next four beats give a correct fresh result.
